// File: rtl/wishbone_arbiter_2m.sv
// rtl/wishbone_arbiter_2m.sv - two-master round-robin Wishbone arbiter with per-grant stall watchdog
module wishbone_arbiter_2m #(
   parameter int ADR_W   = 12,
   parameter int DAT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   output logic [DAT_W-1:0] m0_dat_o,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   output logic [DAT_W-1:0] m1_dat_o,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,
   output logic [1:0]       gnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic       last, last_nxt;
   logic [7:0] wd;
   logic       m0_err_q, m1_err_q;
   logic       owner_stb;

   // Next-state: round-robin on contention from IDLE, direct handover when the owner releases cyc
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? OWN0 : OWN1;
            else if (m0_cyc_i)        state_nxt = OWN0;
            else if (m1_cyc_i)        state_nxt = OWN1;
         end
         OWN0: if (!m0_cyc_i) state_nxt = m1_cyc_i ? OWN1 : IDLE;
         OWN1: if (!m1_cyc_i) state_nxt = m0_cyc_i ? OWN0 : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         if (state_nxt == OWN0)      last_nxt = 1'b0;
         else if (state_nxt == OWN1) last_nxt = 1'b1;
      end
   end

   // Slave-side mux and master-side gating, all driven from the registered grant
   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m0_dat_o  = '0;
      m1_dat_o  = '0;
      m0_ack_o  = 1'b0;
      m1_ack_o  = 1'b0;
      owner_stb = 1'b0;
      case (state)
         OWN0: begin
            s_cyc_o   = m0_cyc_i;
            s_stb_o   = m0_stb_i;
            s_we_o    = m0_we_i;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            m0_dat_o  = s_dat_i;
            m0_ack_o  = s_ack_i;
            owner_stb = m0_stb_i;
         end
         OWN1: begin
            s_cyc_o   = m1_cyc_i;
            s_stb_o   = m1_stb_i;
            s_we_o    = m1_we_i;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            m1_dat_o  = s_dat_i;
            m1_ack_o  = s_ack_i;
            owner_stb = m1_stb_i;
         end
         default: ;
      endcase
   end

   // State, priority pointer and watchdog; a grant change or ack always beats a pending timeout
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last     <= 1'b1;
         wd       <= 8'd0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         if (state_nxt != state || s_ack_i || !owner_stb) begin
            wd <= 8'd0;
         end else if (wd == 8'(TIMEOUT - 1)) begin
            wd <= 8'd0;
            if (state == OWN0) m0_err_q <= 1'b1;
            if (state == OWN1) m1_err_q <= 1'b1;
         end else begin
            wd <= wd + 8'd1;
         end
      end
   end

   assign m0_err_o = m0_err_q;
   assign m1_err_o = m1_err_q;
   assign gnt_o    = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// tb/tb_wishbone_arbiter_2m.sv - directed vector bench for wishbone_arbiter_2m
module tb_wishbone_arbiter_2m;

   typedef struct {
      logic        rst;
      logic        c0, s0, w0;
      logic [11:0] a0;
      logic [7:0]  d0;
      logic        c1, s1, w1;
      logic [11:0] a1;
      logic [7:0]  d1;
      logic [7:0]  sd;
      logic        ack;
      logic [1:0]  gnt;
      logic        e0, e1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [11:0] m0_adr, m1_adr, s_adr;
   logic [7:0]  m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack;
   logic [1:0]  gnt;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   wishbone_arbiter_2m #(.ADR_W(12), .DAT_W(8), .TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack), .gnt_o(gnt)
   );

   function automatic vec_t mk(input logic r, input logic c0, input logic s0, input logic w0,
                               input logic [11:0] a0, input logic [7:0] d0,
                               input logic c1, input logic s1, input logic w1,
                               input logic [11:0] a1, input logic [7:0] d1,
                               input logic [7:0] sd, input logic ack,
                               input logic [1:0] g, input logic e0, input logic e1);
      vec_t v;
      v.rst = r; v.c0 = c0; v.s0 = s0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.sd = sd; v.ack = ack; v.gnt = g; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   function automatic vec_t idle(input logic [1:0] g);
      return mk(0, 0,0,0,12'h0,8'h0, 0,0,0,12'h0,8'h0, 8'h0, 0, g, 0, 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL step %0d %s: got %0h expected %0h", step_no, name, act, exp);
      end
   endtask

   // One clock cycle: drive the vector after the edge, check mid-cycle
   task automatic step(input vec_t v);
      logic        ex_cyc, ex_stb, ex_we;
      logic [11:0] ex_adr;
      logic [7:0]  ex_dat;
      @(posedge clk);
      #1;
      rst = v.rst;
      m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.w0; m0_adr = v.a0; m0_dat_i = v.d0;
      m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.w1; m1_adr = v.a1; m1_dat_i = v.d1;
      s_dat_i = v.sd; s_ack = v.ack;
      #2;
      ex_cyc = 0; ex_stb = 0; ex_we = 0; ex_adr = '0; ex_dat = '0;
      if (v.gnt == 2'b01) begin
         ex_cyc = v.c0; ex_stb = v.s0; ex_we = v.w0; ex_adr = v.a0; ex_dat = v.d0;
      end else if (v.gnt == 2'b10) begin
         ex_cyc = v.c1; ex_stb = v.s1; ex_we = v.w1; ex_adr = v.a1; ex_dat = v.d1;
      end
      chk("gnt_o", 32'(gnt), 32'(v.gnt));
      chk("s_cyc_o", 32'(s_cyc), 32'(ex_cyc));
      chk("s_stb_o", 32'(s_stb), 32'(ex_stb));
      chk("s_we_o", 32'(s_we), 32'(ex_we));
      chk("s_adr_o", 32'(s_adr), 32'(ex_adr));
      chk("s_dat_o", 32'(s_dat_o), 32'(ex_dat));
      chk("m0_ack_o", 32'(m0_ack), 32'(v.gnt[0] & v.ack));
      chk("m1_ack_o", 32'(m1_ack), 32'(v.gnt[1] & v.ack));
      chk("m0_dat_o", 32'(m0_dat_o), 32'(v.gnt[0] ? v.sd : 8'h0));
      chk("m1_dat_o", 32'(m1_dat_o), 32'(v.gnt[1] ? v.sd : 8'h0));
      chk("m0_err_o", 32'(m0_err), 32'(v.e0));
      chk("m1_err_o", 32'(m1_err), 32'(v.e1));
      step_no++;
   endtask

   initial begin
      rst = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_i = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_i = '0;
      s_dat_i = '0; s_ack = 0;

      // reset, then single m0 write
      tbl.push_back(mk(1, 0,0,0,12'h0,8'h0, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(idle(2'b00));
      tbl.push_back(mk(0, 1,1,1,12'h0A5,8'h3C, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(mk(0, 1,1,1,12'h0A5,8'h3C, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b01, 0, 0));
      tbl.push_back(mk(0, 1,1,1,12'h0A5,8'h3C, 0,0,0,12'h0,8'h0, 8'h55, 1, 2'b01, 0, 0));
      tbl.push_back(idle(2'b01));
      tbl.push_back(idle(2'b00));
      // contention after reset: m0, direct handover to m1, then m0 again
      tbl.push_back(mk(1, 0,0,0,12'h0,8'h0, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h010,8'h00, 1,1,0,12'h020,8'h00, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h010,8'h00, 1,1,0,12'h020,8'h00, 8'h0, 0, 2'b01, 0, 0));
      tbl.push_back(mk(0, 0,0,0,12'h010,8'h00, 1,1,0,12'h020,8'h00, 8'h0, 0, 2'b01, 0, 0));
      tbl.push_back(mk(0, 0,0,0,12'h010,8'h00, 1,1,0,12'h020,8'h00, 8'h7E, 1, 2'b10, 0, 0));
      tbl.push_back(idle(2'b10));
      tbl.push_back(mk(0, 1,1,1,12'h011,8'h21, 1,1,1,12'h021,8'h22, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(mk(0, 1,1,1,12'h011,8'h21, 1,1,1,12'h021,8'h22, 8'h0, 0, 2'b01, 0, 0));
      tbl.push_back(idle(2'b01));
      tbl.push_back(idle(2'b00));
      // m1 burst of three reads while m0 keeps requesting
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 1,1,0,12'h100,8'h00, 8'h0, 0, 2'b00, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 1,1,0,12'h100,8'h00, 8'hA1, 1, 2'b10, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 1,1,0,12'h101,8'h00, 8'hA2, 1, 2'b10, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 1,1,0,12'h102,8'h00, 8'hA3, 1, 2'b10, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 0,0,0,12'h102,8'h00, 8'h0, 0, 2'b10, 0, 0));
      tbl.push_back(mk(0, 1,1,0,12'h0F0,8'h00, 0,0,0,12'h000,8'h00, 8'h0, 0, 2'b01, 0, 0));
      tbl.push_back(idle(2'b01));
      tbl.push_back(idle(2'b00));

      foreach (tbl[i]) step(tbl[i]);

      // watchdog: slave never acks, err exactly 16 cycles after first stb in grant
      step(mk(0, 1,1,0,12'h0C0,8'h0, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b00, 0, 0));
      for (int k = 0; k < 20; k++)
         step(mk(0, 1,1,0,12'h0C0,8'h0, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b01, (k == 16), 0));
      step(idle(2'b01));
      step(idle(2'b00));

      // reset while m1 owns the bus with stb high
      step(mk(0, 0,0,0,12'h0,8'h0, 1,1,1,12'h3FF,8'h99, 8'h0, 0, 2'b00, 0, 0));
      step(mk(0, 0,0,0,12'h0,8'h0, 1,1,1,12'h3FF,8'h99, 8'h0, 0, 2'b10, 0, 0));
      step(mk(1, 1,1,0,12'h011,8'h0, 1,1,1,12'h3FF,8'h99, 8'h0, 0, 2'b10, 0, 0));
      step(mk(0, 1,1,0,12'h011,8'h0, 1,1,1,12'h3FF,8'h99, 8'h0, 0, 2'b00, 0, 0));
      step(mk(0, 1,1,0,12'h011,8'h0, 1,1,1,12'h3FF,8'h99, 8'h0, 0, 2'b01, 0, 0));
      step(idle(2'b01));
      step(idle(2'b00));

      // ack on the threshold cycle suppresses err and restarts the count
      step(mk(0, 1,1,1,12'h055,8'h44, 0,0,0,12'h0,8'h0, 8'h0, 0, 2'b00, 0, 0));
      for (int k = 0; k < 34; k++)
         step(mk(0, 1,1,1,12'h055,8'h44, 0,0,0,12'h0,8'h0, 8'h0, (k == 15), 2'b01, (k == 32), 0));
      step(idle(2'b01));
      step(idle(2'b00));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
